// File: rtl/periph_handshake_rx_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : periph_handshake_rx_if
// Brief    : Four-phase send/ack write port plus FWFT read port bundle.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface periph_handshake_rx_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] dado;
  logic              send;
  logic              ack;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              underflow;

  // Processor/consumer side
  modport master (
    output dado, send, rd_en,
    input  ack, rd_data, empty, full, count, underflow
  );

  // Peripheral side
  modport slave (
    input  dado, send, rd_en,
    output ack, rd_data, empty, full, count, underflow
  );
endinterface
`default_nettype wire

// File: rtl/periph_handshake_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : periph_handshake_rx
// Brief    : Four-phase handshake receiver feeding a first-word-fall-through
//            buffer of DEPTH words with sticky underflow detection.
// Revision : 1.0
// ---------------------------------------------------------------------------
module periph_handshake_rx #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  wire                        clk,
  input  wire                        rst,
  periph_handshake_rx_if.slave       bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_ACKED = 1'b1;

  localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(DEPTH);

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic              r_ack;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_underflow;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_wr;
  logic w_rd;

  // Flags decoded only from the registered count
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FULL_CNT);

  assign w_wr = (r_state == c_IDLE) && bus.send && !w_full;
  assign w_rd = bus.rd_en && !w_empty;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (bus.send && !w_full) w_state_nxt = c_ACKED;
      c_ACKED: if (!bus.send)           w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= (w_state_nxt == c_ACKED);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_tail <= r_tail + PTR_W'(1);
      if (w_rd) r_head <= r_head + PTR_W'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_underflow <= 1'b0;
    else if (bus.rd_en && w_empty)
      r_underflow <= 1'b1;
  end

  // Storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_tail] <= bus.dado;
  end

  assign bus.ack       = r_ack;
  assign bus.rd_data   = r_mem[r_head];
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.count     = r_count;
  assign bus.underflow = r_underflow;
endmodule
`default_nettype wire

// File: doc/periph_handshake_rx.md
PERIPH_HANDSHAKE_RX -- requirements
Module: periph_handshake_rx

Interface
REQ-001 Parameter DATA_W, default 16, width of the transferred data word.
REQ-002 Parameter DEPTH, default 4, number of buffered words; power of two, minimum 2.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port dado  input  DATA_W  data word offered by the processor.
REQ-006 Port send  input  1  processor request; stays high until ack is seen high.
REQ-007 Port ack  output  1  peripheral acknowledge, driven directly from a register.
REQ-008 Port rd_en  input  1  consumer pops the head word this cycle.
REQ-009 Port rd_data  output  DATA_W  head word in first-word-fall-through order; valid when empty=0.
REQ-010 Port empty  output  1  buffer holds zero words.
REQ-011 Port full  output  1  buffer holds DEPTH words.
REQ-012 Port count  output  $clog2(DEPTH+1)  number of words held.
REQ-013 Port underflow  output  1  sticky flag, set by rd_en while empty.

Function
REQ-014 The handshake FSM SHALL have exactly two states: IDLE (ack=0) and ACKED (ack=1).
REQ-015 In IDLE with send=1 and full=0 at a rising edge, the block SHALL write dado into the tail slot on that edge and enter ACKED.
REQ-016 In IDLE with send=1 and full=1, the block SHALL stay in IDLE, hold ack=0 and write nothing; no data is lost or overwritten.
REQ-017 In ACKED with send=1, the block SHALL stay in ACKED and write nothing.
REQ-018 In ACKED with send=0 at a rising edge, the block SHALL return to IDLE.
REQ-019 Each four-phase transaction (send up, ack up, send down, ack down) SHALL write exactly one word.
REQ-020 Latency: ack SHALL rise one edge after send is sampled high with full=0, and SHALL fall one edge after send is sampled low.
REQ-021 A second word SHALL be accepted no earlier than the edge after ack has fallen.
REQ-022 rd_en=1 with empty=0 SHALL advance the head pointer on that edge; rd_data SHALL then show the next word with no added cycle.
REQ-023 rd_en=1 with empty=1 SHALL leave pointers and count unchanged and SHALL set underflow.
REQ-024 A simultaneous write and read SHALL leave count unchanged and advance both pointers.
REQ-025 full SHALL be judged from count before the edge, so a write is refused when full=1 even if rd_en=1 in the same cycle.
REQ-026 Head and tail pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no special case.
REQ-027 empty, full and count SHALL be registered state or decoded only from registered state.
REQ-028 Buffer contents are not reset; rd_data is undefined while empty=1.

Reset
REQ-029 Asserting rst SHALL immediately force IDLE, ack=0, head=tail=0, count=0, empty=1, full=0 and underflow=0, without waiting for a clock edge.
REQ-030 Reset asserted during ACKED SHALL drop ack at once; a word already written is discarded because count is cleared.
REQ-031 After rst is released, the first rising edge SHALL be evaluated normally; if send=1 there, a new transaction begins.
REQ-032 underflow SHALL be cleared only by rst.

Verification
REQ-033 Single transfer: dado=16'hA5A5, raise send -> ack=1 on the next edge, count=1, rd_data=16'hA5A5; drop send -> ack=0 one edge later.
REQ-034 Fill and stall (DEPTH=4): complete four transfers 1..4 -> full=1; fifth send with dado=5 -> ack stays 0. Pop once -> fifth ack rises; pops then return 2,3,4,5 in order.
REQ-035 Wrap-around: run 10 push/pop pairs with values 0..9 -> every pop matches FIFO order, count never exceeds 1, pointers wrap with no error.
REQ-036 Simultaneous access: count=2, a write accepted in the same edge as rd_en=1 -> count stays 2 and rd_data becomes the second-oldest word.
REQ-037 Underflow: rd_en=1 while empty -> underflow=1, count=0; the flag stays 1 across later valid traffic until rst.
REQ-038 Async reset mid-handshake: pulse rst between clock edges while ack=1 and count=3 -> ack=0, count=0, empty=1 before the next edge; a new handshake after release stores one word.
